// File: rtl/uart_rx_frame_ctrl_pkg.sv
// uart_rx_frame_ctrl_pkg: parity encodings, FSM states and voting helper shared by the UART RX controller
package uart_rx_frame_ctrl_pkg;
  localparam int OVERSAMPLE_DEF = 8;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD = 2'd2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction
endpackage

// File: rtl/uart_rx_frame_ctrl_tick.sv
// uart_rx_tick_gen: free-running divider giving a one-clock oversampling tick every io_clockDivider+1 clocks
// Ports: io_mainClk, resetCtrl_systemReset (sync, active high), io_clockDivider (period-1), io_tick (pulse)
module uart_rx_tick_gen #(
  parameter int DIV_W = 20
) (
  input  logic             io_mainClk,
  input  logic             resetCtrl_systemReset,
  input  logic [DIV_W-1:0] io_clockDivider,
  output logic             io_tick
);
  logic [DIV_W-1:0] divCnt;
  // >= so that lowering the divider on the fly cannot strand the counter above the terminal count
  assign io_tick = divCnt >= io_clockDivider;
  always_ff @(posedge io_mainClk)
    divCnt <= (resetCtrl_systemReset || io_tick) ? '0 : divCnt + 1'b1;
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: oversampled UART receiver with majority vote, parity/stop checks and a one-byte valid/ready buffer
// Ports: io_mainClk, resetCtrl_systemReset (sync, active high), io_rxSync (synchronized line),
//   config io_clockDivider/io_dataLength/io_parity/io_stop, stream io_read_valid/ready/payload,
//   one-clock pulses io_errParity/io_errFrame/io_break/io_overflow, io_busy while a frame is in progress
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_W = 20
) (
  input  logic             io_mainClk,
  input  logic             resetCtrl_systemReset,
  input  logic             io_rxSync,
  input  logic [DIV_W-1:0] io_clockDivider,
  input  logic [2:0]       io_dataLength,
  input  logic [1:0]       io_parity,
  input  logic             io_stop,
  output logic             io_read_valid,
  input  logic             io_read_ready,
  output logic [7:0]       io_read_payload,
  output logic             io_errParity,
  output logic             io_errFrame,
  output logic             io_break,
  output logic             io_overflow,
  output logic             io_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  state_e state;
  logic tick, vote, isDecision, isBitEnd, parEn, lastStop, stopLow, canLoad;
  logic parAcc, parErr, frameErr, allZero;
  logic [1:0] histPrev;
  logic [TW-1:0] tickCnt;
  logic [2:0] bitCnt;
  logic [7:0] shiftData;
  uart_rx_tick_gen #(.DIV_W(DIV_W)) tickGen (
    .io_mainClk(io_mainClk),
    .resetCtrl_systemReset(resetCtrl_systemReset),
    .io_clockDivider(io_clockDivider),
    .io_tick(tick)
  );
  // the 3-sample history is the two stored samples plus the one being taken on this tick,
  // so the decision tick votes over samples OVERSAMPLE/2-1 .. OVERSAMPLE/2+1
  assign vote = majority3({histPrev, io_rxSync});
  assign isDecision = tick && tickCnt == TW'(OVERSAMPLE / 2 + 1);
  assign isBitEnd = tick && tickCnt == TW'(OVERSAMPLE - 1);
  assign parEn = io_parity == PAR_EVEN || io_parity == PAR_ODD;
  assign lastStop = bitCnt[0] || !io_stop;
  assign stopLow = frameErr || !vote;
  assign canLoad = !io_read_valid || io_read_ready;
  assign io_busy = state != IDLE;
  always_ff @(posedge io_mainClk) begin
    io_errParity <= 1'b0;
    io_errFrame <= 1'b0;
    io_break <= 1'b0;
    io_overflow <= 1'b0;
    if (resetCtrl_systemReset) begin
      state <= IDLE;
      histPrev <= 2'b11;
      tickCnt <= '0;
      bitCnt <= '0;
      shiftData <= '0;
      parAcc <= 1'b0;
      parErr <= 1'b0;
      frameErr <= 1'b0;
      allZero <= 1'b1;
      io_read_valid <= 1'b0;
      io_read_payload <= '0;
    end else begin
      if (tick) begin
        histPrev <= {histPrev[0], io_rxSync};
        tickCnt <= isBitEnd ? '0 : tickCnt + 1'b1;
      end
      if (io_read_valid && io_read_ready) io_read_valid <= 1'b0;
      case (state)
        IDLE:
          if (tick && !io_rxSync) begin
            state <= START;
            tickCnt <= TW'(1);
            bitCnt <= '0;
            shiftData <= '0;
            parAcc <= 1'b0;
            parErr <= 1'b0;
            frameErr <= 1'b0;
            allZero <= 1'b1;
          end
        START:
          if (isDecision && vote) state <= IDLE;
          else if (isBitEnd) begin
            state <= DATA;
            bitCnt <= '0;
          end
        DATA: begin
          if (isDecision) begin
            shiftData[bitCnt] <= vote;
            parAcc <= parAcc ^ vote;
            if (vote) allZero <= 1'b0;
          end
          if (isBitEnd) begin
            bitCnt <= bitCnt == io_dataLength ? 3'd0 : bitCnt + 3'd1;
            if (bitCnt == io_dataLength) state <= parEn ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (isDecision) begin
            if (vote != (parAcc ^ (io_parity == PAR_ODD))) parErr <= 1'b1;
            if (vote) allZero <= 1'b0;
          end
          if (isBitEnd) state <= STOP;
        end
        STOP: begin
          if (isDecision && !lastStop) frameErr <= stopLow;
          if (isBitEnd && !lastStop) bitCnt <= 3'd1;
          // deliver at the last stop decision so a start bit right behind it is not missed
          if (isDecision && lastStop) begin
            state <= IDLE;
            io_errParity <= parErr;
            io_errFrame <= stopLow;
            io_break <= stopLow && allZero;
            io_overflow <= !canLoad;
            if (canLoad) begin
              io_read_valid <= 1'b1;
              io_read_payload <= shiftData;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
  logic io_mainClk = 1'b0;
  logic resetCtrl_systemReset = 1'b1;
  logic io_rxSync = 1'b1;
  logic [19:0] io_clockDivider = 20'd3;
  logic [2:0] io_dataLength = 3'd7;
  logic [1:0] io_parity = 2'd0;
  logic io_stop = 1'b0;
  logic io_read_ready = 1'b1;
  logic io_read_valid, io_errParity, io_errFrame, io_break, io_overflow, io_busy;
  logic [7:0] io_read_payload;
  int nTests = 0, nFail = 0;
  int nValid = 0, nPar = 0, nFrm = 0, nBrk = 0, nOvf = 0, nGot = 0;
  int bValid, bPar, bFrm, bBrk, bOvf, bGot;
  int bitClk = 32;
  logic [7:0] got [0:63];

  uart_rx_frame_ctrl dut (
    .io_mainClk(io_mainClk),
    .resetCtrl_systemReset(resetCtrl_systemReset),
    .io_rxSync(io_rxSync),
    .io_clockDivider(io_clockDivider),
    .io_dataLength(io_dataLength),
    .io_parity(io_parity),
    .io_stop(io_stop),
    .io_read_valid(io_read_valid),
    .io_read_ready(io_read_ready),
    .io_read_payload(io_read_payload),
    .io_errParity(io_errParity),
    .io_errFrame(io_errFrame),
    .io_break(io_break),
    .io_overflow(io_overflow),
    .io_busy(io_busy)
  );

  always #5 io_mainClk = ~io_mainClk;

  always @(negedge io_mainClk) begin
    if (io_read_valid) nValid++;
    if (io_read_valid && io_read_ready && nGot < 64) begin
      got[nGot] = io_read_payload;
      nGot++;
    end
    if (io_errParity) nPar++;
    if (io_errFrame) nFrm++;
    if (io_break) nBrk++;
    if (io_overflow) nOvf++;
  end

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge io_mainClk);
      #1;
    end
  endtask

  task automatic mark();
    bValid = nValid; bPar = nPar; bFrm = nFrm; bBrk = nBrk; bOvf = nOvf; bGot = nGot;
  endtask

  task automatic sendBit(input logic b);
    io_rxSync = b;
    step(bitClk);
  endtask

  task automatic sendFrame(input logic [7:0] d, input int nb, input int par, input logic flip, input int nStop);
    logic p;
    p = 1'b0;
    sendBit(1'b0);
    for (int i = 0; i < nb; i++) begin
      sendBit(d[i]);
      p ^= d[i];
    end
    if (par != 0) sendBit((par == 2 ? ~p : p) ^ flip);
    for (int i = 0; i < nStop; i++) sendBit(1'b1);
  endtask

  initial begin
    step(5);
    checkVal("rst_valid", 32'(io_read_valid), 0);
    checkVal("rst_payload", 32'(io_read_payload), 0);
    checkVal("rst_busy", 32'(io_busy), 0);
    checkVal("rst_pulses", 32'({io_errParity, io_errFrame, io_break, io_overflow}), 0);
    resetCtrl_systemReset = 1'b0;
    step(3);
    // 8N1 0xA5, ready high
    mark();
    sendFrame(8'hA5, 8, 0, 1'b0, 1);
    step(2 * bitClk);
    checkVal("t1_count", 32'(nGot - bGot), 1);
    checkVal("t1_payload", 32'(got[bGot]), 32'hA5);
    checkVal("t1_valid_width", 32'(nValid - bValid), 1);
    checkVal("t1_errors", 32'(nPar - bPar + nFrm - bFrm + nBrk - bBrk + nOvf - bOvf), 0);
    checkVal("t1_busy", 32'(io_busy), 0);
    // 7E2 0x3C with flipped parity bit
    io_dataLength = 3'd6; io_parity = 2'd1; io_stop = 1'b1;
    mark();
    sendFrame(8'h3C, 7, 1, 1'b1, 2);
    step(2 * bitClk);
    checkVal("t2_payload", 32'(got[bGot]), 32'h3C);
    checkVal("t2_errParity", 32'(nPar - bPar), 1);
    checkVal("t2_errFrame", 32'(nFrm - bFrm), 0);
    // 8-clock glitch on idle line
    io_dataLength = 3'd7; io_parity = 2'd0; io_stop = 1'b0;
    mark();
    io_rxSync = 1'b0;
    step(8);
    io_rxSync = 1'b1;
    step(4);
    checkVal("t3_busy_during", 32'(io_busy), 1);
    step(3 * bitClk);
    checkVal("t3_busy_after", 32'(io_busy), 0);
    checkVal("t3_no_valid", 32'(nValid - bValid), 0);
    // line held low 12 bit times
    mark();
    io_rxSync = 1'b0;
    step(12 * bitClk);
    io_rxSync = 1'b1;
    step(14 * bitClk);
    checkVal("t4_got_any", 32'(nGot > bGot), 1);
    checkVal("t4_payload", 32'(got[bGot]), 0);
    checkVal("t4_errFrame", 32'(nFrm - bFrm), 1);
    checkVal("t4_break", 32'(nBrk - bBrk), 1);
    checkVal("t4_errParity", 32'(nPar - bPar), 0);
    // overflow: ready low, two back-to-back bytes
    io_read_ready = 1'b0;
    mark();
    sendFrame(8'h11, 8, 0, 1'b0, 1);
    sendFrame(8'h22, 8, 0, 1'b0, 1);
    step(bitClk);
    checkVal("t5_valid", 32'(io_read_valid), 1);
    checkVal("t5_payload_held", 32'(io_read_payload), 32'h11);
    checkVal("t5_overflow", 32'(nOvf - bOvf), 1);
    checkVal("t5_no_read", 32'(nGot - bGot), 0);
    io_read_ready = 1'b1;
    step(3);
    checkVal("t5_read_count", 32'(nGot - bGot), 1);
    checkVal("t5_read_byte", 32'(got[bGot]), 32'h11);
    checkVal("t5_valid_clear", 32'(io_read_valid), 0);
    // reset in the middle of 0x55 data bits, then 0x0F
    mark();
    sendBit(1'b0); sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    io_rxSync = 1'b0;
    step(bitClk / 2);
    resetCtrl_systemReset = 1'b1;
    step(2);
    io_rxSync = 1'b1;
    checkVal("t6_rst_busy", 32'(io_busy), 0);
    resetCtrl_systemReset = 1'b0;
    step(2 * bitClk);
    sendFrame(8'h0F, 8, 0, 1'b0, 1);
    step(2 * bitClk);
    checkVal("t6_count", 32'(nGot - bGot), 1);
    checkVal("t6_payload", 32'(got[bGot]), 32'h0F);
    checkVal("t6_errors", 32'(nPar - bPar + nFrm - bFrm + nBrk - bBrk + nOvf - bOvf), 0);
    // divider 0 (tick every clock), 8O1 good then bad parity
    io_clockDivider = 20'd0; io_parity = 2'd2; bitClk = 8;
    step(20);
    mark();
    sendFrame(8'h5A, 8, 2, 1'b0, 1);
    step(2 * bitClk);
    checkVal("t7_payload", 32'(got[bGot]), 32'h5A);
    checkVal("t7_no_parerr", 32'(nPar - bPar), 0);
    mark();
    sendFrame(8'hC3, 8, 2, 1'b1, 1);
    step(2 * bitClk);
    checkVal("t7_payload2", 32'(got[bGot]), 32'hC3);
    checkVal("t7_parerr", 32'(nPar - bPar), 1);
    checkVal("t7_errFrame", 32'(nFrm - bFrm), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

UART receive controller that sequences the oversampled RX datapath: it consumes the already-synchronized RX line, generates the oversampling tick, detects start bits, majority-votes each bit, assembles the character, checks parity/stop, and hands bytes out on a valid/ready stream. It sits between the RX synchronizer and the UART register/FIFO block of the peripheral.

## Interface
- OVERSAMPLE, 8: ticks per bit; legal 4..16, even.
- DIV_W, 20: width of io_clockDivider.
- io_mainClk  in  1  system clock; all logic on rising edge.
- resetCtrl_systemReset  in  1  synchronous, active-high reset.
- io_rxSync  in  1  synchronized RX line (idle high).
- io_clockDivider  in  DIV_W  tick period minus one, in clocks.
- io_dataLength  in  3  data bits = value+1 (1..8).
- io_parity  in  2  0 none, 1 even, 2 odd, 3 reserved (treated as none).
- io_stop  in  1  0 one stop bit, 1 two stop bits.
- io_read_valid  out  1  byte available.
- io_read_ready  in  1  consumer accepts byte.
- io_read_payload  out  8  received byte, LSB first on line, unused MSBs zero.
- io_errParity  out  1  one-clock pulse, parity mismatch.
- io_errFrame  out  1  one-clock pulse, stop bit sampled low.
- io_break  out  1  one-clock pulse, frame error with all data and parity bits zero.
- io_overflow  out  1  one-clock pulse, byte completed while buffer full.
- io_busy  out  1  FSM not in IDLE.

## Operation
- Tick: divider counter counts 0..io_clockDivider, tick = 1-clock pulse at terminal count; counter free-running, never resynchronized.
- Sampler: on each tick shift io_rxSync into 3-bit history; vote = majority of history.
- Bit timing: tickCnt 0..OVERSAMPLE-1 per bit; bit decision on tick where tickCnt == OVERSAMPLE/2+1 (samples at OVERSAMPLE/2-1..+1); bit ends on tick where tickCnt == OVERSAMPLE-1.
- FSM states IDLE, START, DATA, PARITY, STOP.
  - IDLE: on tick with io_rxSync==0 -> START, tickCnt=1.
  - START: at decision, vote==1 -> IDLE (glitch rejected, no output); else continue; at bit end -> DATA, bitCnt=0.
  - DATA: at decision store vote at payload[bitCnt], update parity; at bit end bitCnt==io_dataLength -> PARITY if parity enabled else STOP; else bitCnt+1.
  - PARITY: at decision compare vote with computed bit (even: XOR of data; odd: inverted); at bit end -> STOP.
  - STOP: at decision vote==0 sets frame error. With io_stop=1, second stop bit also checked. At decision of last stop bit -> deliver, -> IDLE immediately (do not wait bit end, allows back-to-back start).
- Deliver: if io_read_valid==0 or handshake completes same clock, load payload, valid=1; else drop new byte, pulse io_overflow, keep old byte. Error/break pulses fire on deliver clock regardless of overflow; errored bytes still delivered.
- Output buffer: valid cleared on valid&&ready; payload stable while valid.
- Config inputs sampled live; changing them mid-frame is undefined, must not hang FSM (any state returns to IDLE within one frame).

## Timing
- Reset: io_read_valid, io_read_payload, all pulses, io_busy = 0; FSM IDLE; counters 0; sample history = 3'b111.
- Reset mid-frame: frame discarded, no pulses.
- Latency: io_read_valid high one clock after the tick of the last stop-bit decision.
- Pulses exactly one io_mainClk wide.
- io_clockDivider=0: tick every clock, must still work.

## Structure
- Shared package: parity encodings (PAR_NONE/EVEN/ODD), FSM state enum, OVERSAMPLE default.
- One natural sub-module: uart_rx_tick_gen (divider counter, tick output).
- Synchronizer stays outside; this block assumes io_rxSync already metastability-safe.

## Test plan
- Divider=3 (bit=32 clk), 8N1, send 0xA5, ready=1 -> payload 0xA5, valid one clock, no error pulses.
- 7E2, send 0x3C with wrong parity bit -> payload 0x3C, io_errParity pulse, no frame error.
- 8N1, low glitch of 8 clk (2 ticks) on idle line -> no valid, FSM back to IDLE, io_busy falls.
- 8N1, line held low 12 bit times -> payload 0x00, io_errFrame and io_break pulses.
- ready=0, send 0x11 then 0x22 back-to-back -> payload stays 0x11, io_overflow pulse at second deliver; ready=1 then reads 0x11.
- Reset asserted mid-DATA of 0x55 then released, then send 0x0F -> only 0x0F delivered, no error pulses.
